// File: rtl/fetch_sequencer_if.sv
// Fetch-stage bus: instruction-memory port, decode-side valid/stall handshake,
// branch redirect and fault reporting, bundled for the fetch_sequencer.
//
// Handshake: an instruction is consumed by decode on a cycle where if_valid=1,
// stall=0 and redirect=0. While stall=1 and if_valid=1, if_inst/if_pc stay
// stable. An instruction shown in a redirect cycle is squashed.
interface fetch_sequencer_if;
  logic [31:0] imem_pc;
  logic [31:0] imem_inst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        fault;
  logic [31:0] fault_pc;
  logic        dbg_state;

  modport master (
    output imem_pc, if_valid, if_inst, if_pc, fault, fault_pc, dbg_state,
    input  imem_inst, stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_pc, if_valid, if_inst, if_pc, fault, fault_pc, dbg_state,
    output imem_inst, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller for a synchronous-read instruction memory:
// PC generation, one-cycle read-latency absorption, stall hold, redirect, fault trap.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 32
) (
  input logic         clock,
  input logic         reset,
  fetch_sequencer_if.master bus
);

  typedef enum logic {RUN = 1'b0, FAULT = 1'b1} state_t;

  localparam logic [29:0] MEM_LIMIT = 30'(MEM_WORDS);

  state_t      state, state_n;
  logic [31:0] fetch_pc, fetch_pc_n;
  logic        out_valid, out_valid_n;
  logic [31:0] out_pc, out_pc_n;
  logic        use_hold, use_hold_n;
  logic [31:0] hold_inst, hold_inst_n;
  logic        fault, fault_n;
  logic [31:0] fault_pc, fault_pc_n;
  logic        fetch_ok;

  assign fetch_ok = (fetch_pc[1:0] == 2'b00) && (fetch_pc[31:2] < MEM_LIMIT);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= RUN;
      fetch_pc  <= RESET_PC;
      out_valid <= 1'b0;
      out_pc    <= 32'h0;
      use_hold  <= 1'b0;
      hold_inst <= 32'h0;
      fault     <= 1'b0;
      fault_pc  <= 32'h0;
    end else begin
      state     <= state_n;
      fetch_pc  <= fetch_pc_n;
      out_valid <= out_valid_n;
      out_pc    <= out_pc_n;
      use_hold  <= use_hold_n;
      hold_inst <= hold_inst_n;
      fault     <= fault_n;
      fault_pc  <= fault_pc_n;
    end
  end

  always_comb begin
    state_n     = state;
    fetch_pc_n  = fetch_pc;
    out_valid_n = out_valid;
    out_pc_n    = out_pc;
    use_hold_n  = use_hold;
    hold_inst_n = hold_inst;
    fault_n     = fault;
    fault_pc_n  = fault_pc;

    if (bus.redirect) begin
      state_n     = RUN;
      fetch_pc_n  = bus.redirect_pc;
      out_valid_n = 1'b0;
      use_hold_n  = 1'b0;
      fault_n     = 1'b0;
    end else if (state == FAULT) begin
      out_valid_n = 1'b0;
    end else if (bus.stall && out_valid) begin
      // Capture the shown word once; the memory re-reads fetch_pc meanwhile
      // so its data is discarded and reused when the stall lifts.
      if (!use_hold) begin
        hold_inst_n = bus.imem_inst;
        use_hold_n  = 1'b1;
      end
    end else begin
      use_hold_n = 1'b0;
      out_pc_n   = fetch_pc;
      if (fetch_ok) begin
        out_valid_n = 1'b1;
        fetch_pc_n  = fetch_pc + 32'd4;
      end else begin
        out_valid_n = 1'b0;
        fault_n     = 1'b1;
        fault_pc_n  = fetch_pc;
        state_n     = FAULT;
      end
    end
  end

  assign bus.imem_pc   = fetch_pc;
  assign bus.if_valid  = out_valid;
  assign bus.if_pc     = out_pc;
  assign bus.if_inst   = use_hold ? hold_inst : bus.imem_inst;
  assign bus.fault     = fault;
  assign bus.fault_pc  = fault_pc;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: behavioural instruction memory,
// per-scenario tasks with inline checks, and an in-order delivery scoreboard.
module tb_fetch_sequencer;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  logic [63:0] exp_q[$];

  fetch_sequencer_if bus ();

  fetch_sequencer #(
    .RESET_PC  (32'h0000_0000),
    .MEM_WORDS (32)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous-read memory: word k holds A000_0000 + k
  always @(posedge clock) bus.imem_inst <= 32'hA000_0000 + (bus.imem_pc >> 2);

  // Scoreboard: pop on every consumed instruction
  always @(negedge clock) begin
    logic [63:0] exp;
    if (bus.if_valid === 1'b1 && bus.stall === 1'b0 && bus.redirect === 1'b0 && reset === 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_extra: got pc=%h inst=%h, required no delivery", bus.if_pc, bus.if_inst);
      end else begin
        exp = exp_q.pop_front();
        if ({bus.if_pc, bus.if_inst} !== exp) begin
          errors++;
          $display("FAIL scoreboard_delivery: got pc=%h inst=%h, required pc=%h inst=%h",
                   bus.if_pc, bus.if_inst, exp[63:32], exp[31:0]);
        end
      end
    end
  end

  // Driver tasks
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_q.push_back({pc, 32'hA000_0000 + (pc >> 2)});
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;
    cyc();
    cyc();
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid: got %b required 0", bus.if_valid); end
    checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b required 0", bus.fault); end
    checks++; if (bus.imem_pc !== 32'h0) begin errors++; $display("FAIL reset_imem_pc: got %h required 0", bus.imem_pc); end
    checks++; if (bus.if_pc !== 32'h0) begin errors++; $display("FAIL reset_if_pc: got %h required 0", bus.if_pc); end
    checks++; if (bus.fault_pc !== 32'h0) begin errors++; $display("FAIL reset_fault_pc: got %h required 0", bus.fault_pc); end
    checks++; if (bus.dbg_state !== 1'b0) begin errors++; $display("FAIL reset_state: got %b required 0", bus.dbg_state); end
    push_exp(32'h0);
    push_exp(32'h4);
    reset = 1'b0;
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL cycle0_if_valid: got %b required 0", bus.if_valid); end
    cyc();
    checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0) begin
      errors++; $display("FAIL first_fetch: got valid=%b pc=%h required valid=1 pc=0", bus.if_valid, bus.if_pc);
    end
    cyc();
  endtask

  task automatic test_stall();
    push_exp(32'h8);
    push_exp(32'hC);
    cyc();
    bus.stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.stall = 1'b0;
      checks++;
      if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h8 || bus.if_inst !== 32'hA000_0002) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got valid=%b pc=%h inst=%h required valid=1 pc=8 inst=a0000002",
                 i, bus.if_valid, bus.if_pc, bus.if_inst);
      end
      if (i < 3) cyc();
    end
    cyc();
    checks++;
    if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'hC || bus.if_inst !== 32'hA000_0003) begin
      errors++;
      $display("FAIL stall_release: got valid=%b pc=%h inst=%h required valid=1 pc=c inst=a0000003",
               bus.if_valid, bus.if_pc, bus.if_inst);
    end
  endtask

  task automatic test_redirect();
    cyc();
    checks++; if (bus.if_pc !== 32'h10) begin errors++; $display("FAIL redirect_pre_pc: got %h required 10", bus.if_pc); end
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h40;
    push_exp(32'h40);
    push_exp(32'h44);
    cyc();
    bus.redirect = 1'b0;
    checks++; if (bus.if_valid !== 1'b0 || bus.imem_pc !== 32'h40) begin
      errors++; $display("FAIL redirect_bubble: got valid=%b imem_pc=%h required valid=0 imem_pc=40", bus.if_valid, bus.imem_pc);
    end
    cyc();
    checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h40 || bus.if_inst !== 32'hA000_0010) begin
      errors++; $display("FAIL redirect_target: got valid=%b pc=%h inst=%h required valid=1 pc=40 inst=a0000010",
                         bus.if_valid, bus.if_pc, bus.if_inst);
    end
    cyc();
    checks++; if (bus.if_pc !== 32'h44) begin errors++; $display("FAIL redirect_next: got %h required 44", bus.if_pc); end
  endtask

  task automatic test_fault_end();
    for (int a = 'h48; a <= 'h7C; a += 4) begin
      push_exp(32'(a));
      cyc();
      checks++;
      if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'(a)) begin
        errors++; $display("FAIL seq_fetch: got valid=%b pc=%h required valid=1 pc=%h", bus.if_valid, bus.if_pc, 32'(a));
      end
    end
    bus.stall = 1'b1;
    cyc();
    bus.stall = 1'b0;
    checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h7C || bus.fault !== 1'b0) begin
      errors++; $display("FAIL last_good_stalled: got valid=%b pc=%h fault=%b required valid=1 pc=7c fault=0",
                         bus.if_valid, bus.if_pc, bus.fault);
    end
    cyc();
    checks++; if (bus.fault !== 1'b1 || bus.fault_pc !== 32'h80 || bus.if_valid !== 1'b0 || bus.dbg_state !== 1'b1) begin
      errors++; $display("FAIL range_fault: got fault=%b fault_pc=%h valid=%b state=%b required fault=1 fault_pc=80 valid=0 state=1",
                         bus.fault, bus.fault_pc, bus.if_valid, bus.dbg_state);
    end
    bus.stall = 1'b1;
    cyc();
    cyc();
    bus.stall = 1'b0;
    checks++; if (bus.fault !== 1'b1 || bus.if_valid !== 1'b0 || bus.imem_pc !== 32'h80) begin
      errors++; $display("FAIL fault_frozen: got fault=%b valid=%b imem_pc=%h required fault=1 valid=0 imem_pc=80",
                         bus.fault, bus.if_valid, bus.imem_pc);
    end
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0;
    push_exp(32'h0);
    push_exp(32'h4);
    cyc();
    bus.redirect = 1'b0;
    checks++; if (bus.fault !== 1'b0 || bus.if_valid !== 1'b0 || bus.imem_pc !== 32'h0 || bus.dbg_state !== 1'b0) begin
      errors++; $display("FAIL fault_clear: got fault=%b valid=%b imem_pc=%h state=%b required fault=0 valid=0 imem_pc=0 state=0",
                         bus.fault, bus.if_valid, bus.imem_pc, bus.dbg_state);
    end
    cyc();
    checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0) begin
      errors++; $display("FAIL resume_pc: got valid=%b pc=%h required valid=1 pc=0", bus.if_valid, bus.if_pc);
    end
    cyc();
  endtask

  task automatic test_misaligned();
    cyc();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h6;
    cyc();
    bus.redirect = 1'b0;
    checks++; if (bus.if_valid !== 1'b0 || bus.imem_pc !== 32'h6) begin
      errors++; $display("FAIL misalign_redirect: got valid=%b imem_pc=%h required valid=0 imem_pc=6", bus.if_valid, bus.imem_pc);
    end
    cyc();
    checks++; if (bus.fault !== 1'b1 || bus.fault_pc !== 32'h6 || bus.if_valid !== 1'b0) begin
      errors++; $display("FAIL misalign_fault: got fault=%b fault_pc=%h valid=%b required fault=1 fault_pc=6 valid=0",
                         bus.fault, bus.fault_pc, bus.if_valid);
    end
    cyc();
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL misalign_no_valid: got %b required 0", bus.if_valid); end
  endtask

  task automatic test_redirect_stall();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h20;
    cyc();
    bus.redirect = 1'b0;
    checks++; if (bus.fault !== 1'b0 || bus.imem_pc !== 32'h20) begin
      errors++; $display("FAIL rs_redirect: got fault=%b imem_pc=%h required fault=0 imem_pc=20", bus.fault, bus.imem_pc);
    end
    cyc();
    bus.stall = 1'b1;
    cyc();
    checks++; if (bus.if_pc !== 32'h20 || bus.if_inst !== 32'hA000_0008) begin
      errors++; $display("FAIL rs_held: got pc=%h inst=%h required pc=20 inst=a0000008", bus.if_pc, bus.if_inst);
    end
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h30;
    push_exp(32'h30);
    cyc();
    bus.redirect = 1'b0;
    checks++; if (bus.if_valid !== 1'b0 || bus.imem_pc !== 32'h30) begin
      errors++; $display("FAIL rs_redirect_wins: got valid=%b imem_pc=%h required valid=0 imem_pc=30", bus.if_valid, bus.imem_pc);
    end
    cyc();
    bus.stall = 1'b0;
    checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h30 || bus.if_inst !== 32'hA000_000C) begin
      errors++; $display("FAIL rs_target: got valid=%b pc=%h inst=%h required valid=1 pc=30 inst=a000000c",
                         bus.if_valid, bus.if_pc, bus.if_inst);
    end
  endtask

  task automatic test_reset_mid_stall();
    cyc();
    bus.stall = 1'b1;
    cyc();
    checks++; if (bus.if_pc !== 32'h34 || bus.if_inst !== 32'hA000_000D) begin
      errors++; $display("FAIL rm_held: got pc=%h inst=%h required pc=34 inst=a000000d", bus.if_pc, bus.if_inst);
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    bus.stall = 1'b0;
    checks++; if (bus.if_valid !== 1'b0 || bus.fault !== 1'b0 || bus.imem_pc !== 32'h0) begin
      errors++; $display("FAIL rm_reset: got valid=%b fault=%b imem_pc=%h required valid=0 fault=0 imem_pc=0",
                         bus.if_valid, bus.fault, bus.imem_pc);
    end
    push_exp(32'h0);
    push_exp(32'h4);
    push_exp(32'h8);
    for (int a = 0; a <= 8; a += 4) begin
      cyc();
      checks++;
      if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'(a) || bus.if_inst !== 32'hA000_0000 + 32'(a / 4)) begin
        errors++; $display("FAIL rm_restart: got valid=%b pc=%h inst=%h required valid=1 pc=%h",
                           bus.if_valid, bus.if_pc, bus.if_inst, 32'(a));
      end
    end
  endtask

  // Watchdog
  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: time limit reached before end of test");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    checks = 0;
    errors = 0;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;
    test_reset();
    test_stall();
    test_redirect();
    test_fault_end();
    test_misaligned();
    test_redirect_stall();
    test_reset_mid_stall();
    cyc();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller that sequences the 32-word, synchronous-read instruction memory. It generates the PC each cycle and absorbs the memory's one-cycle read latency. It presents instructions to decode with a valid/stall handshake, handles branch redirects, and traps fetches that are misaligned or outside the memory. It sits between the instruction memory and the decode stage and owns the architectural fetch PC.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset
- MEM_WORDS, 32, instruction memory depth in words; legal PCs are 0 .. 4*MEM_WORDS-4
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- imem_pc  out  32  address to memory PC port; registered
- imem_inst  in  32  memory Inst; holds mem[pc/4] for the imem_pc sampled at the previous edge
- stall  in  1  decode cannot accept the current instruction this cycle
- redirect  in  1  load a new PC (branch/jump); kills everything in flight
- redirect_pc  in  32  target PC, sampled when redirect=1
- if_valid  out  1  if_inst/if_pc hold a real instruction
- if_inst  out  32  instruction word
- if_pc  out  32  byte address of if_inst
- fault  out  1  sticky fetch fault
- fault_pc  out  32  offending PC, valid while fault=1

## Operation
- State: fetch_pc (=imem_pc), out_valid, out_pc, use_hold, hold_inst, fault, fault_pc; FSM RUN/FAULT.
- fetch_ok = (fetch_pc[1:0]==0) && (fetch_pc[31:2] < MEM_WORDS).
- Output mux: if_inst = use_hold ? hold_inst : imem_inst. if_pc = out_pc. if_valid = out_valid.
- Priority per edge: reset > redirect > hold (stall && out_valid) > advance.
- Reset: fetch_pc=RESET_PC, out_valid=0, out_pc=0, use_hold=0, hold_inst=0, fault=0, fault_pc=0, state RUN.
- Redirect (any state): fetch_pc<=redirect_pc, out_valid<=0, use_hold<=0, fault<=0, state RUN. The instruction shown in the redirect cycle is treated as squashed by the consumer.
- Hold (stall=1 and out_valid=1): fetch_pc, out_pc and out_valid keep their values.
  - If use_hold=0: hold_inst<=imem_inst and use_hold<=1.
  - The memory's read of fetch_pc in this cycle is discarded.
- Advance (RUN, not hold):
  - use_hold<=0, out_pc<=fetch_pc.
  - If fetch_ok: out_valid<=1, fetch_pc<=fetch_pc+4 (mod 2^32).
  - Else: out_valid<=0, fault<=1, fault_pc<=fetch_pc, state FAULT.
- Stall with out_valid=0 has no effect; fetch advances.
- FAULT: fetch_pc frozen, out_valid=0. Stall is ignored. Exit only by redirect or reset.

## Timing
- The memory read is registered, so an address driven in cycle n is returned in cycle n+1.
- Reset released at edge 0 → cycle 0 drives RESET_PC → cycle 1 if_valid=1, if_pc=RESET_PC. Throughput is then 1 instruction/cycle.
- Redirect asserted in cycle n:
  - cycle n+1: if_valid=0, imem_pc=redirect_pc
  - cycle n+2: if_valid=1, if_pc=redirect_pc
  - Penalty is 1 bubble.
- Stall in cycles n..m-1, released in m: if_inst/if_pc stay constant n..m. Cycle m+1 shows the next sequential PC with no bubble.
- Redirect and stall in the same cycle: the redirect wins and the hold is dropped.
- A bad PC reaching the advance edge: fault=1 and if_valid=0 in the next cycle. The preceding good instruction is still delivered normally, including under stall.
- PC wrap 32'hFFFF_FFFC+4 → 0 is arithmetic only; with default MEM_WORDS it faults before then.

## Test plan
- Bench memory word k = 32'hA000_0000+k. Reset 2 cycles then release → if_valid first high 1 cycle later. Then if_pc = 0,4,8,... and if_inst = A000_0000, A000_0001, ... on consecutive cycles.
- Stall 3 cycles while if_pc=0x8 → if_inst=A000_0002 held for 4 cycles total. The next cycle gives if_pc=0xC, if_inst=A000_0003, with no bubble.
- Redirect to 0x40 while if_pc=0x10 → one cycle if_valid=0, then if_pc=0x40, inst A000_0010, then 0x44.
- Sequential fetch to 0x7C → 0x7C delivered. Next cycle fault=1, fault_pc=0x80, if_valid=0 until redirect to 0x0, after which fault clears and fetch resumes at 0x0.
- Redirect to 0x6 → fault=1, fault_pc=0x6, never if_valid for it. Redirect and stall together during a hold → redirect wins and the held instruction is dropped.
- Reset asserted mid-stall with use_hold=1 → next cycle if_valid=0, fault=0, imem_pc=RESET_PC. Fetch restarts as in scenario 1.
